// File: rtl/moore_seq_detect.sv
// Moore serial pattern detector; KMP next-state table is derived from PATTERN at elaboration.
// Optional saturating match counter is built only when MOORE_SEQ_COUNT_EN is defined.
module moore_seq_detect #(
    parameter int unsigned     PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned     CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         x,
    input  logic                         overlap,
    output logic                         z,
    output logic [$clog2(PLEN+1)-1:0]    state,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int unsigned   SW    = $clog2(PLEN + 1);
    localparam logic [SW-1:0] SFULL = SW'(PLEN);

    // Longest pattern prefix that is a suffix of (first k pattern bits, xb).
    function automatic int unsigned kmp_next(input int unsigned k, input logic xb);
        logic [PLEN:0]   seq;
        logic [PLEN:0]   mask;
        logic [PLEN:0]   pre;
        logic [PLEN-1:0] sh;
        int unsigned     best;
        seq  = '0;
        best = 0;
        for (int unsigned i = 0; i < k; i++) begin
            sh  = PATTERN >> (PLEN - 1 - i);
            seq = {seq[PLEN-1:0], sh[0]};
        end
        seq = {seq[PLEN-1:0], xb};
        for (int unsigned j = 1; j <= PLEN; j++) begin
            if (j <= k + 1) begin
                mask = {(PLEN + 1){1'b1}} >> (PLEN + 1 - j);
                pre  = {1'b0, PATTERN} >> (PLEN - j);
                if ((seq & mask) == (pre & mask)) best = j;
            end
        end
        return best;
    endfunction

    logic [SW-1:0] nxt0 [PLEN+1];
    logic [SW-1:0] nxt1 [PLEN+1];

    for (genvar k = 0; k <= PLEN; k++) begin : g_kmp
        assign nxt0[k] = SW'(kmp_next(k, 1'b0));
        assign nxt1[k] = SW'(kmp_next(k, 1'b1));
    end

    logic [SW-1:0] state_q, state_d, kidx;

    always_comb begin
        state_d = state_q;
        kidx    = state_q;
        if (state_q > SFULL) begin
            state_d = '0;
        end else if (en) begin
            // Non-overlapping mode restarts from S0 after a full match.
            if (state_q == SFULL && !overlap) kidx = '0;
            state_d = x ? nxt1[kidx] : nxt0[kidx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= '0;
        else        state_q <= state_d;
    end

    assign state = state_q;
    assign z     = (state_q == SFULL);

`ifdef MOORE_SEQ_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (state_q <= SFULL) && (state_d == SFULL) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: table vectors for two parameter sets, then random stimulus
// against a history-based reference model.
module tb_moore_seq_detect;

`ifdef MOORE_SEQ_COUNT_EN
    localparam bit cnt_on = 1'b1;
`else
    localparam bit cnt_on = 1'b0;
`endif

    typedef struct {
        logic r;
        logic e;
        logic x;
        logic ov;
        int   st;
        int   z;
        int   cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_en, a_x, a_ov, a_z;
    logic [2:0] a_state;
    logic [7:0] a_cnt;
    logic       b_reset, b_en, b_x, b_ov, b_z;
    logic [1:0] b_state;
    logic [1:0] b_cnt;

    moore_seq_detect #(.PLEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .x(a_x), .overlap(a_ov),
        .z(a_z), .state(a_state), .match_cnt(a_cnt)
    );

    moore_seq_detect #(.PLEN(3), .PATTERN(3'b111), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .x(b_x), .overlap(b_ov),
        .z(b_z), .state(b_state), .match_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cur_st, cur_z, cur_cnt;

    // Reference model: bit history (newest in bit 0) plus matched length and count.
    int unsigned m_hist [2];
    int unsigned m_hlen [2];
    int unsigned m_k    [2];
    int unsigned m_cnt  [2];
    int unsigned m_pat  [2];
    int unsigned m_plen [2];
    int unsigned m_cmax [2];

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic int unsigned best_match(input int unsigned hist, input int unsigned hlen,
                                               input int unsigned pat, input int unsigned plen);
        int unsigned mask;
        for (int unsigned j = plen; j >= 1; j--) begin
            mask = (32'd1 << j) - 32'd1;
            if (j <= hlen && (hist & mask) == ((pat >> (plen - j)) & mask)) return j;
        end
        return 0;
    endfunction

    task automatic model_update(input int d, input logic r, input logic e, input logic xv,
                                input logic ov);
        if (!r) begin
            m_hist[d] = 0;
            m_hlen[d] = 0;
            m_k[d]    = 0;
            m_cnt[d]  = 0;
        end else if (e) begin
            if (m_k[d] == m_plen[d] && !ov) begin
                m_hist[d] = 0;
                m_hlen[d] = 0;
            end
            m_hist[d] = (m_hist[d] << 1) | {31'b0, xv};
            if (m_hlen[d] < 32) m_hlen[d] = m_hlen[d] + 1;
            m_k[d] = best_match(m_hist[d], m_hlen[d], m_pat[d], m_plen[d]);
            if (m_k[d] == m_plen[d] && m_cnt[d] < m_cmax[d]) m_cnt[d] = m_cnt[d] + 1;
        end
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input int d, input logic r, input logic e, input logic xv,
                        input logic ov, input int idx);
        if (d == 0) begin
            a_reset = r; a_en = e; a_x = xv; a_ov = ov;
            b_reset = 1'b1; b_en = 1'b0;
        end else begin
            b_reset = r; b_en = e; b_x = xv; b_ov = ov;
            a_reset = 1'b1; a_en = 1'b0;
        end
        @(posedge clk);
        #1;
        model_update(d, r, e, xv, ov);
        if (d == 0) begin
            cur_st = int'(a_state); cur_z = int'(a_z); cur_cnt = int'(a_cnt);
        end else begin
            cur_st = int'(b_state); cur_z = int'(b_z); cur_cnt = int'(b_cnt);
        end
        chk(d == 0 ? "model_state_a" : "model_state_b", idx, cur_st, int'(m_k[d]));
        chk(d == 0 ? "model_z_a" : "model_z_b", idx, cur_z, (m_k[d] == m_plen[d]) ? 1 : 0);
        chk(d == 0 ? "model_cnt_a" : "model_cnt_b", idx, cur_cnt,
            cnt_on ? int'(m_cnt[d]) : 0);
    endtask

    task automatic add_a(input logic r, input logic e, input logic xv, input logic ov,
                         input int st, input int zz, input int cnt);
        tbl_a.push_back('{r, e, xv, ov, st, zz, cnt});
    endtask

    task automatic add_b(input logic r, input logic e, input logic xv, input logic ov,
                         input int st, input int zz, input int cnt);
        tbl_b.push_back('{r, e, xv, ov, st, zz, cnt});
    endtask

    task automatic run_table(input int d);
        int n;
        vec_t v;
        n = (d == 0) ? tbl_a.size() : tbl_b.size();
        for (int i = 0; i < n; i++) begin
            v = (d == 0) ? tbl_a[i] : tbl_b[i];
            step(d, v.r, v.e, v.x, v.ov, i);
            chk(d == 0 ? "tbl_state_a" : "tbl_state_b", i, cur_st, v.st);
            chk(d == 0 ? "tbl_z_a" : "tbl_z_b", i, cur_z, v.z);
            chk(d == 0 ? "tbl_cnt_a" : "tbl_cnt_b", i, cur_cnt, cnt_on ? v.cnt : 0);
        end
    endtask

    initial begin
        m_pat[0] = 32'hB; m_plen[0] = 4; m_cmax[0] = 255;
        m_pat[1] = 32'h7; m_plen[1] = 3; m_cmax[1] = 3;
        for (int d = 0; d < 2; d++) begin
            m_hist[d] = 0; m_hlen[d] = 0; m_k[d] = 0; m_cnt[d] = 0;
        end
        a_reset = 1'b0; a_en = 1'b0; a_x = 1'b0; a_ov = 1'b0;
        b_reset = 1'b0; b_en = 1'b0; b_x = 1'b0; b_ov = 1'b0;

        // Reset held with en=1, x=1.
        add_a(0, 1, 1, 0, 0, 0, 0);
        add_a(0, 1, 1, 0, 0, 0, 0);
        // Non-overlapping 1,0,1,1,0,1,1.
        add_a(1, 1, 1, 0, 1, 0, 0);
        add_a(1, 1, 0, 0, 2, 0, 0);
        add_a(1, 1, 1, 0, 3, 0, 0);
        add_a(1, 1, 1, 0, 4, 1, 1);
        add_a(1, 1, 0, 0, 0, 0, 1);
        add_a(1, 1, 1, 0, 1, 0, 1);
        add_a(1, 1, 1, 0, 1, 0, 1);
        // Overlapping, same stream.
        add_a(0, 1, 1, 1, 0, 0, 0);
        add_a(1, 1, 1, 1, 1, 0, 0);
        add_a(1, 1, 0, 1, 2, 0, 0);
        add_a(1, 1, 1, 1, 3, 0, 0);
        add_a(1, 1, 1, 1, 4, 1, 1);
        add_a(1, 1, 0, 1, 2, 0, 1);
        add_a(1, 1, 1, 1, 3, 0, 1);
        add_a(1, 1, 1, 1, 4, 1, 2);
        // Enable gating.
        add_a(0, 1, 1, 0, 0, 0, 0);
        add_a(1, 1, 1, 0, 1, 0, 0);
        add_a(1, 1, 0, 0, 2, 0, 0);
        add_a(1, 1, 1, 0, 3, 0, 0);
        add_a(1, 0, 0, 0, 3, 0, 0);
        add_a(1, 0, 1, 1, 3, 0, 0);
        add_a(1, 0, 0, 0, 3, 0, 0);
        add_a(1, 1, 1, 0, 4, 1, 1);
        add_a(1, 0, 0, 1, 4, 1, 1);
        add_a(1, 0, 1, 1, 4, 1, 1);
        add_a(1, 1, 0, 0, 0, 0, 1);
        // Reset mid-pattern.
        add_a(1, 1, 1, 0, 1, 0, 1);
        add_a(1, 1, 0, 0, 2, 0, 1);
        add_a(1, 1, 1, 0, 3, 0, 1);
        add_a(0, 1, 1, 0, 0, 0, 0);
        add_a(1, 1, 1, 0, 1, 0, 0);

        // Pattern 111, 2-bit counter: saturation, hold, then non-overlap restart.
        add_b(0, 1, 1, 1, 0, 0, 0);
        add_b(1, 1, 1, 1, 1, 0, 0);
        add_b(1, 1, 1, 1, 2, 0, 0);
        add_b(1, 1, 1, 1, 3, 1, 1);
        add_b(1, 1, 1, 1, 3, 1, 2);
        add_b(1, 1, 1, 1, 3, 1, 3);
        add_b(1, 1, 1, 1, 3, 1, 3);
        add_b(1, 0, 0, 1, 3, 1, 3);
        add_b(1, 1, 1, 0, 1, 0, 3);
        add_b(1, 1, 1, 0, 2, 0, 3);
        add_b(1, 1, 1, 0, 3, 1, 3);
        add_b(1, 1, 0, 1, 0, 0, 3);

        run_table(0);
        run_table(1);

        for (int i = 0; i < 400; i++) begin
            step(0, logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), i);
        end
        for (int i = 0; i < 300; i++) begin
            step(1, logic'($urandom_range(0, 59) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
# moore_seq_detect

Parametrised Moore-type serial sequence detector, successor to the single-bit toggle FSM. It samples a serial input `x` under an enable, tracks how much of a compile-time pattern has been matched, and raises a registered Moore output `z` while the full pattern is matched. Overlap behaviour is selectable at run time, and an optional saturating match counter can be compiled in. It sits directly on a serial bit stream in the same designs as the toggle FSM.

## Interface
- `PLEN`, 4: pattern length in bits, ≥ 2.
- `PATTERN`, 4'b1011: pattern, `PLEN` bits; `PATTERN[PLEN-1]` is the first bit received.
- `CNT_W`, 8: match counter width, ≥ 1.

- `clk`  in  1  rising-edge clock, single clock domain.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `en`  in  1  sample enable; `x` is consumed only on edges where `en`=1.
- `x`  in  1  serial data bit.
- `overlap`  in  1  1 = overlapping matches, 0 = non-overlapping; sampled each enabled edge.
- `z`  out  1  Moore match output, registered.
- `state`  out  $clog2(PLEN+1)  current state index k (0..PLEN), for debug and verification.
- `match_cnt`  out  CNT_W  saturating count of completed matches.

## Operation
- States S0..S_PLEN. S_k means the last k consumed bits equal the first k pattern bits, and k is maximal.
- Decode is Moore only: `z` = (state == S_PLEN). `z` never depends combinationally on `x`, `en` or `overlap`.
- Transition on an edge with `reset`=1, `en`=1, from S_k (k < PLEN) with input `x`:
  - next = S_j, where j is the largest value such that the first j pattern bits equal the suffix of (matched k bits followed by `x`).
  - This is KMP next-state logic. It is computed from `PATTERN` at elaboration by a function/generate, with no runtime tables.
- From S_PLEN with `overlap`=1: apply the same rule with k = PLEN, so a matched suffix is reused.
- From S_PLEN with `overlap`=0: transition as from S0. Next is S1 if `x` == `PATTERN[PLEN-1]`, else S0.
- `en`=0: state holds, so `z` holds and `match_cnt` holds.
- `match_cnt`:
  - Increments by 1 on each enabled edge whose next state is S_PLEN.
  - Consecutive re-entries into S_PLEN each count.
  - Saturates at all-ones and never wraps.
- Reset values: state = S0, `z` = 0, `match_cnt` = 0.

## Timing
- The state register updates on the `clk` rising edge.
- Latency: `z` rises in the cycle after the edge that consumed the final pattern bit. `match_cnt` updates on that same edge.
- `z` stays high for exactly as many consecutive cycles as the state stays S_PLEN. With `en`=0 in S_PLEN, it stays high indefinitely.
- Reset priority: `reset`=0 overrides `en`, `x` and `overlap` on the same edge. A reset mid-pattern discards the partial match, and the next enabled bit is evaluated from S0.
- Changing `overlap` while in S_PLEN takes effect on the next enabled edge. It has no effect while `en`=0.
- No state is illegal. Unused encodings of `state` above PLEN decode to S0 on the next edge, and `z` = 0 while in them.

## Configuration
- Macro: `MOORE_SEQ_COUNT_EN`.
- Defined: the `match_cnt` register and its saturating incrementer are built as described.
- Undefined: no counter logic is built. `match_cnt` is driven constant 0, and the port remains so the port list is unchanged.
- State and `z` behaviour is identical in both builds.

## Test plan
- Reset: `reset`=0 for 2 cycles with `en`=1, `x`=1 → `state`=0, `z`=0, `match_cnt`=0 on every cycle.
- Non-overlap with defaults (1011), `overlap`=0, enabled stream 1,0,1,1,0,1,1:
  - `state` = 1,2,3,4,0,1,1.
  - `z` high exactly one cycle, after the 4th bit.
  - `match_cnt`=1.
- Overlap, same stream with `overlap`=1:
  - `state` = 1,2,3,4,2,3,4.
  - `z` high after bits 4 and 7.
  - `match_cnt`=2.
- Enable gating: feed 1,0,1, then hold `en`=0 for 3 cycles while toggling `x`, then enable with `x`=1:
  - `state` holds 3 while `en`=0, then goes to 4.
  - `z` high one cycle later.
- Reset mid-pattern: feed 1,0,1 (`state`=3), then `reset`=0 for one edge with `en`=1, `x`=1:
  - `state`=0.
  - Next enabled `x`=1 gives `state`=1, not 4.
  - `match_cnt` back at 0.
- Saturation and alternate parameters, `PLEN`=3, `PATTERN`=3'b111, `CNT_W`=2, `overlap`=1, six consecutive 1s:
  - `z` high after bits 3,4,5,6.
  - `match_cnt` = 1,2,3,3, holding at 3.
  - With `MOORE_SEQ_COUNT_EN` undefined, `match_cnt` = 0 throughout and `z` is unchanged.
